// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: valid/ready handshake with a main entry, one skid
// entry and flush. Control bits are gated to zero whenever no entry is valid.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] rs2_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
  logic [DATA_W-1:0] m_alu_q,  s_alu_q;
  logic [DATA_W-1:0] m_rs2_q,  s_rs2_q;
  logic [ADDR_W-1:0] m_rd_q,   s_rd_q;

  logic load_m_in, load_m_skid, load_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state and entry-load decisions; flush beats every transition.
  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid_i) begin
            load_m_in = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (in_valid_i && out_ready_i) begin
            load_m_in = 1'b1;
          end else if (!in_valid_i && out_ready_i) begin
            state_d = EMPTY;
          end else if (in_valid_i && !out_ready_i) begin
            load_s  = 1'b1;
            state_d = SKID;
          end
        end
        SKID: begin
          if (out_ready_i) begin
            load_m_skid = 1'b1;
            state_d     = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry storage; data fields survive a flush, only reset clears them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      m_ctrl_q <= '0;
      m_alu_q  <= '0;
      m_rs2_q  <= '0;
      m_rd_q   <= '0;
      s_ctrl_q <= '0;
      s_alu_q  <= '0;
      s_rs2_q  <= '0;
      s_rd_q   <= '0;
    end else begin
      if (load_m_in) begin
        m_ctrl_q <= ctrl_i;
        m_alu_q  <= alu_i;
        m_rs2_q  <= rs2_i;
        m_rd_q   <= rd_i;
      end else if (load_m_skid) begin
        m_ctrl_q <= s_ctrl_q;
        m_alu_q  <= s_alu_q;
        m_rs2_q  <= s_rs2_q;
        m_rd_q   <= s_rd_q;
      end
      if (load_s) begin
        s_ctrl_q <= ctrl_i;
        s_alu_q  <= alu_i;
        s_rs2_q  <= rs2_i;
        s_rd_q   <= rd_i;
      end
    end
  end

  // Outputs decoded from registered state only; ctrl gated by valid.
  always_comb begin
    in_ready_o  = (state_q != SKID);
    out_valid_o = (state_q != EMPTY);
    ctrl_o      = out_valid_o ? m_ctrl_q : '0;
    alu_o       = m_alu_q;
    rs2_o       = m_rs2_q;
    rd_o        = m_rd_q;
    unique case (state_q)
      FULL:    count_o = 2'd1;
      SKID:    count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage (default widths) plus a randomized queue
// model run on a wide-parameter instance.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-width instance
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [3:0]  ctrl_i, ctrl_o;
  logic [31:0] alu_i, rs2_i, alu_o, rs2_o;
  logic [4:0]  rd_i, rd_o;
  logic [1:0]  count_o;

  ex_mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ctrl_i(ctrl_i), .alu_i(alu_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .alu_o(alu_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .count_o(count_o)
  );

  // Wide instance
  logic        p_rst, p_flush, p_in_valid, p_out_ready;
  logic        p_in_ready, p_out_valid;
  logic [5:0]  p_ctrl_i, p_ctrl_o;
  logic [63:0] p_alu_i, p_rs2_i, p_alu_o, p_rs2_o;
  logic [5:0]  p_rd_i, p_rd_o;
  logic [1:0]  p_count;

  ex_mem_stage #(.DATA_W(64), .CTRL_W(6), .ADDR_W(6)) dut_w (
    .clk_i(clk), .rst_i(p_rst), .flush_i(p_flush),
    .in_valid_i(p_in_valid), .in_ready_o(p_in_ready),
    .ctrl_i(p_ctrl_i), .alu_i(p_alu_i), .rs2_i(p_rs2_i), .rd_i(p_rd_i),
    .out_valid_o(p_out_valid), .out_ready_i(p_out_ready),
    .ctrl_o(p_ctrl_o), .alu_o(p_alu_o), .rs2_o(p_rs2_o), .rd_o(p_rd_o),
    .count_o(p_count)
  );

  typedef struct packed {
    logic [5:0]  c;
    logic [63:0] a;
    logic [63:0] r;
    logic [5:0]  d;
  } ent_t;

  ent_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic rdy);
    in_valid_i  = v;
    alu_i       = a;
    out_ready_i = rdy;
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
    ctrl_i = 4'h0; alu_i = 32'h99; rs2_i = 32'h0; rd_i = 5'd0;
    p_rst = 1'b0; p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0;
    p_ctrl_i = '0; p_alu_i = '0; p_rs2_i = '0; p_rd_i = '0;

    // 1. Reset held with input valid, then a 3-deep stream
    tick(); tick();
    check("rst_valid", out_valid_o, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_alu", alu_o, 0);
    check("rst_rs2", rs2_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", in_ready_o, 1);
    rst_i = 1'b1;
    drive(1, 32'h11, 1); tick();
    check("s1_valid", out_valid_o, 1);
    check("s1_alu", alu_o, 32'h11);
    check("s1_count", count_o, 1);
    drive(1, 32'h22, 1); tick();
    check("s2_alu", alu_o, 32'h22);
    check("s2_count", count_o, 1);
    drive(1, 32'h33, 1); tick();
    check("s3_alu", alu_o, 32'h33);
    check("s3_count", count_o, 1);
    drive(0, 32'h0, 1); tick();
    check("s_drain_valid", out_valid_o, 0);

    // 2. Stall into skid, ignored input, drain in order
    drive(1, 32'hA, 1); tick();
    check("k_a_alu", alu_o, 32'hA);
    drive(1, 32'hB, 0); tick();
    check("k_count2", count_o, 2);
    check("k_ready0", in_ready_o, 0);
    check("k_hold_a", alu_o, 32'hA);
    drive(1, 32'hC, 0); tick();
    check("k_c_ign_count", count_o, 2);
    check("k_c_ign_alu", alu_o, 32'hA);
    drive(0, 32'h0, 1);
    check("k_out_a", alu_o, 32'hA);
    tick();
    check("k_out_b", alu_o, 32'hB);
    check("k_out_b_valid", out_valid_o, 1);
    check("k_out_b_count", count_o, 1);
    tick();
    check("k_empty", out_valid_o, 0);
    tick();
    check("k_no_c", out_valid_o, 0);
    check("k_no_c_count", count_o, 0);

    // 3. Flush in SKID with a valid input presented
    drive(1, 32'h1, 1); tick();
    drive(1, 32'h2, 0); tick();
    check("f_pre_count", count_o, 2);
    flush_i = 1'b1; ctrl_i = 4'b1001; drive(1, 32'h3, 0); tick();
    check("f_valid", out_valid_o, 0);
    check("f_ctrl", ctrl_o, 0);
    check("f_count", count_o, 0);
    check("f_ready", in_ready_o, 1);
    check("f_data_kept", alu_o, 32'h1);
    flush_i = 1'b0; ctrl_i = 4'h0; drive(0, 32'h0, 1); tick();
    check("f_gone", out_valid_o, 0);

    // 4. Control gating
    ctrl_i = 4'b1111; rd_i = 5'd7; drive(1, 32'h44, 0); tick();
    check("g_ctrl_on", ctrl_o, 4'b1111);
    check("g_rd", rd_o, 7);
    ctrl_i = 4'h0; rd_i = 5'd0; drive(0, 32'h0, 1); tick();
    check("g_ctrl_off", ctrl_o, 0);
    check("g_rd_held", rd_o, 7);

    // 5. Reset from SKID
    drive(1, 32'h5A, 0); tick();
    drive(1, 32'h5B, 0); tick();
    check("r_pre_count", count_o, 2);
    rst_i = 1'b0; drive(1, 32'h66, 1); tick();
    check("r_alu", alu_o, 0);
    check("r_count", count_o, 0);
    check("r_valid", out_valid_o, 0);
    rst_i = 1'b1; drive(1, 32'h55, 1); tick();
    check("r_55", alu_o, 32'h55);
    check("r_55_count", count_o, 1);
    drive(0, 32'h0, 1); tick();
    check("r_alone", out_valid_o, 0);
    check("r_alone_count", count_o, 0);

    // 6. Random traffic on wide instance against a queue model
    p_rst = 1'b1;
    for (int unsigned i = 0; i < 400; i++) begin
      ent_t e;
      logic in_acc, out_acc;
      check("w_valid", p_out_valid, (q.size() != 0));
      check("w_count", p_count, q.size());
      check("w_ready", p_in_ready, (q.size() < 2));
      check("w_ctrl", p_ctrl_o, (q.size() != 0) ? q[0].c : 6'd0);
      if (q.size() != 0) begin
        check("w_alu", p_alu_o, q[0].a);
        check("w_rs2", p_rs2_o, q[0].r);
        check("w_rd", p_rd_o, q[0].d);
      end
      p_in_valid  = ($urandom_range(0, 3) != 0);
      p_out_ready = ($urandom_range(0, 2) != 0);
      p_flush     = ($urandom_range(0, 15) == 0);
      p_ctrl_i    = 6'($urandom_range(0, 63));
      p_alu_i     = {$urandom, $urandom};
      p_rs2_i     = {$urandom, $urandom};
      p_rd_i      = 6'($urandom_range(0, 63));
      e = '{c: p_ctrl_i, a: p_alu_i, r: p_rs2_i, d: p_rd_i};
      if (p_flush) begin
        q.delete();
      end else begin
        in_acc  = p_in_valid && (q.size() < 2);
        out_acc = p_out_ready && (q.size() != 0);
        if (out_acc) void'(q.pop_front());
        if (in_acc) q.push_back(e);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline stage register with valid/ready handshake, a 2-entry skid buffer and flush.
- Sits between the EX and MEM stages of the RISC-V core and carries control bits, the ALU result, rs2 store data and the destination register.
- Replaces the unconditional register with a stage that can:
  - stall without losing data;
  - kill in-flight instructions;
  - keep side-effect control bits (RegWrite, MemWrite, ...) at zero whenever the stage holds no valid instruction.

Parameters:
- DATA_W, 32: width of the ALU result and of the rs2 data fields.
- CTRL_W, 4: width of the control bundle, in order {RegWrite, MemtoReg, MemRead, MemWrite} from MSB to LSB.
- ADDR_W, 5: width of the destination register address.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- flush_i  in  1  kill all held entries and the current input.
- in_valid_i  in  1  EX presents a valid instruction.
- in_ready_o  out  1  stage accepts input this cycle.
- ctrl_i  in  CTRL_W  control bundle from EX.
- alu_i  in  DATA_W  ALU result.
- rs2_i  in  DATA_W  store data.
- rd_i  in  ADDR_W  destination register.
- out_valid_o  out  1  MEM-side entry valid.
- out_ready_i  in  1  MEM consumes the entry this cycle.
- ctrl_o  out  CTRL_W  control bundle; forced to 0 when out_valid_o=0.
- alu_o  out  DATA_W  held ALU result.
- rs2_o  out  DATA_W  held store data.
- rd_o  out  ADDR_W  held destination register.
- count_o  out  2  occupancy, 0..2.

Behaviour:

Transfer rules:
- Input transfer happens when in_valid_i & in_ready_o.
- Output transfer happens when out_valid_o & out_ready_i.

Storage:
- Main entry M drives the outputs.
- Skid entry S holds an accepted instruction while M is stalled.

States:
- EMPTY (count 0), FULL (count 1), SKID (count 2).
- in_ready_o = (state != SKID). It depends only on registered state, with no combinational path from out_ready_i.
- out_valid_o = (state != EMPTY).

Reset (rst_i=0 at a rising edge):
- State becomes EMPTY.
- M and S data fields are cleared to 0.
- After the edge: out_valid_o=0, ctrl_o=0, alu_o=0, rs2_o=0, rd_o=0, count_o=0, in_ready_o=1.
- Inputs are ignored on any edge where rst_i=0. Reset mid-stall discards both entries.

Flush (flush_i=1, rst_i=1):
- Next state is EMPTY and both entries are invalidated.
- The input presented in the same cycle is discarded, even if in_ready_o=1.
- Data fields keep their old values; ctrl_o reads 0 because out_valid_o=0.
- Flush has priority over every transition below.

Transitions (no reset, no flush):
- EMPTY:
  - in_valid_i: M<=input, go to FULL.
  - otherwise stay in EMPTY.
- FULL:
  - in_valid_i & out_ready_i: M<=input, stay in FULL (back-to-back throughput of 1 per cycle).
  - !in_valid_i & out_ready_i: go to EMPTY.
  - in_valid_i & !out_ready_i: S<=input, go to SKID.
  - neither: hold.
- SKID:
  - out_ready_i: M<=S, go to FULL. in_ready_o=0, so input is ignored that cycle.
  - otherwise hold both entries.

Ordering and latency:
- Instructions leave in acceptance order; none is lost or duplicated.
- Latency is 1 cycle: an input accepted at edge N appears on the outputs after edge N if the stage was empty.
- ctrl_o = out_valid_o ? M.ctrl : 0, so a bubble can never assert RegWrite or MemWrite downstream.
- Data fields pass through bit-exact with no arithmetic; widths follow the parameters.

Test Plan:
1. Reset then stream: hold rst_i=0 for 2 cycles with in_valid_i=1 → outputs all 0, count_o=0. Release, present alu=0x11,0x22,0x33 on consecutive cycles with out_ready_i=1 → out_valid_o rises 1 cycle after the first input; alu_o shows 0x11, 0x22, 0x33 on consecutive cycles; count_o stays 1.
2. Stall into skid: with FULL holding 0xA, drop out_ready_i and present 0xB → count_o=2, in_ready_o=0, alu_o holds 0xA. Present 0xC while stalled → ignored. Raise out_ready_i for 3 cycles → outputs 0xA, then 0xB, then out_valid_o=0; 0xC never appears.
3. Flush mid-stall: in SKID state, assert flush_i for 1 cycle with in_valid_i=1, ctrl_i=4'b1001 → next cycle out_valid_o=0, ctrl_o=0, count_o=0, in_ready_o=1. The flushed input never appears.
4. Control gating: accept ctrl_i=4'b1111, rd_i=5'd7, then consume it with no new input → ctrl_o=4'b1111 while valid, then 4'b0000 the next cycle; rd_o keeps holding 7.
5. Reset mid-operation: in SKID state, pull rst_i=0 for 1 cycle with out_ready_i=1 → both entries gone; alu_o=0, count_o=0. The next accepted input 0x55 appears alone.
6. Parameter sweep: DATA_W=64, CTRL_W=6, ADDR_W=6 → run a random valid/ready/flush sequence against a queue model. Outputs must match queue order; ctrl_o must be 0 whenever out_valid_o=0; count_o must equal the model occupancy.
